// File: rtl/hartslag_meter.sv
// Heart-rate front end: synchronizes and debounces the raw pulse, measures the
// beat-to-beat interval in ms, averages it over a 4-beat window and flags a high
// rate or a lost pulse.
module hartslag_meter #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEB_TICKS   = 3,
  parameter int unsigned MIN_IVL_MS  = 250,
  parameter int unsigned MAX_IVL_MS  = 2000,
  parameter int unsigned HOOG_IVL_MS = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hartslag_in,
  output logic [11:0] interval_ms,
  output logic        interval_valid,
  output logic        hartslag_hoog,
  output logic        hartslag_fout
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StMeasure, StTrack, StLost} state_e;

  logic [1:0]    sync_q;
  logic          sync;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          beat;

  state_e        state_q, state_d;
  logic [2:0]    n_q, n_d;
  logic [11:0]   ivl_cnt_q, ivl_cnt_d;
  logic [11:0]   win_q [4];
  logic [11:0]   win_d [4];
  logic [11:0]   interval_q, interval_d;
  logic          hoog_q, hoog_d;
  logic          fout_q, fout_d;
  logic          valid_q, valid_d;

  assign sync = sync_q[1];
  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign beat = deb_q & ~deb_prev_q;

  // Two-flop synchronizer for the asynchronous sensor input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], hartslag_in};
  end

  // 1 ms prescaler and debounce next-state
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync != deb_q) begin
      if (deb_cnt_q == DW'(DEB_TICKS)) begin
        deb_d     = sync;
        deb_cnt_d = '0;
      end else if (tick) begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end else begin
        deb_cnt_d = deb_cnt_q;
      end
    end
  end

  // Prescaler and debounce state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      presc_q    <= presc_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // Measurement FSM, interval counter, window and output update
  always_comb begin
    logic        timeout;
    logic        accept;
    logic        upd;
    logic [13:0] sum;

    state_d    = state_q;
    n_d        = n_q;
    win_d      = win_q;
    interval_d = interval_q;
    hoog_d     = hoog_q;
    fout_d     = fout_q;
    valid_d    = 1'b0;
    upd        = 1'b0;
    ivl_cnt_d  = ivl_cnt_q;
    if (tick && (ivl_cnt_q < 12'(MAX_IVL_MS))) ivl_cnt_d = ivl_cnt_q + 12'd1;

    // Timeout wins over a beat in the same clk; that beat is dropped
    timeout = (ivl_cnt_q == 12'(MAX_IVL_MS));
    accept  = beat && (ivl_cnt_q >= 12'(MIN_IVL_MS));

    case (state_q)
      StIdle: begin
        if (timeout) begin
          state_d = StLost;
        end else if (beat) begin
          state_d = StMeasure;
          n_d     = 3'd0;
        end
      end
      StMeasure, StTrack: begin
        if (timeout) begin
          state_d = StLost;
        end else if (accept) begin
          win_d[3]  = win_q[2];
          win_d[2]  = win_q[1];
          win_d[1]  = win_q[0];
          win_d[0]  = ivl_cnt_q;
          ivl_cnt_d = '0;
          if (state_q == StTrack) begin
            upd = 1'b1;
          end else begin
            n_d = n_q + 3'd1;
            if (n_q == 3'd3) begin
              state_d = StTrack;
              upd     = 1'b1;
            end
          end
        end
      end
      StLost: begin
        // ivl_cnt saturates here, so the timeout test does not apply
        if (beat) begin
          state_d = StMeasure;
          n_d     = 3'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) ivl_cnt_d = '0;

    if ((state_d == StLost) && (state_q != StLost)) begin
      fout_d = 1'b1;
      hoog_d = 1'b0;
      n_d    = 3'd0;
      win_d  = '{default: '0};
    end

    sum = {2'b00, win_d[0]} + {2'b00, win_d[1]} + {2'b00, win_d[2]} + {2'b00, win_d[3]};
    if (upd) begin
      interval_d = 12'(sum >> 2);
      hoog_d     = (12'(sum >> 2) < 12'(HOOG_IVL_MS));
      fout_d     = 1'b0;
      valid_d    = 1'b1;
    end
  end

  // Measurement state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      n_q        <= '0;
      ivl_cnt_q  <= '0;
      win_q      <= '{default: '0};
      interval_q <= '0;
      hoog_q     <= 1'b0;
      fout_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ivl_cnt_q  <= ivl_cnt_d;
      win_q      <= win_d;
      interval_q <= interval_d;
      hoog_q     <= hoog_d;
      fout_q     <= fout_d;
      valid_q    <= valid_d;
    end
  end

  assign interval_ms    = interval_q;
  assign interval_valid = valid_q;
  assign hartslag_hoog  = hoog_q;
  assign hartslag_fout  = fout_q;

endmodule
